// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//   Turns a valid/ready command stream into APB3 transfers, one at a time,
//   and returns a one-cycle response pulse per command. A wait-state
//   counter aborts a transfer whose slave holds PREADY low for TIMEOUT
//   ACCESS cycles. TIMEOUT = 0 disables the abort.
//
// Ports
//   PCLK, PRESET              clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_write/addr/wdata      command payload (wdata ignored for reads)
//   rsp_valid                 one-cycle response pulse, no backpressure
//   rsp_rdata, rsp_err        read data (0 on writes/errors), error flag
//   PSEL/PENABLE/PWRITE       APB control
//   PADDR/PWDATA              APB address / write data
//   PREADY/PSLVERR/PRDATA     APB slave response
module apb_master_bridge #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  input  logic [DATA_W-1:0] PRDATA
);

  // Counter is at least one bit wide so TIMEOUT = 0 still elaborates.
  localparam int unsigned     CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  // Every registered output plus the wait counter, kept together so the
  // output process can start from "hold everything" in one assignment.
  typedef struct packed {
    logic              cmd_ready;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [CNT_W-1:0]  cnt;
  } regs_t;

  state_t state_q, state_d;
  regs_t  q, d;

  logic accept;
  logic xfer_done;
  logic timed_out;

  assign accept    = (state_q == IDLE) && cmd_valid && q.cmd_ready;
  assign xfer_done = (state_q == ACCESS) && PREADY;
  // Abort on the TIMEOUT-th consecutive PREADY-low ACCESS cycle.
  assign timed_out = (state_q == ACCESS) && !PREADY && (TIMEOUT != 0) && (q.cnt == CNT_LAST);

  // State register
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      // NOTE: everything, including the held bus fields, resets so the APB side comes up fully zeroed.
      state_q <= IDLE;
      q       <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q <= state_d;
      q       <= d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (xfer_done || timed_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs
  always_comb begin
    // NOTE: start from the held values so every field has a value on every path and no latch appears.
    d           = q;
    d.rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        d.psel      = 1'b0;
        d.penable   = 1'b0;
        d.cmd_ready = 1'b1;
        if (accept) begin
          d.cmd_ready = 1'b0;
          d.psel      = 1'b1;
          d.pwrite    = cmd_write;
          d.paddr     = cmd_addr;
          d.pwdata    = cmd_wdata;
        end
      end
      SETUP: begin
        d.penable = 1'b1;
        d.cnt     = '0;
      end
      ACCESS: begin
        if (xfer_done) begin
          d.rsp_valid = 1'b1;
          d.rsp_err   = PSLVERR;
          d.rsp_rdata = (!q.pwrite && !PSLVERR) ? PRDATA : '0;
          d.psel      = 1'b0;
          d.penable   = 1'b0;
          d.cmd_ready = 1'b1;
        end else if (timed_out) begin
          d.rsp_valid = 1'b1;
          d.rsp_err   = 1'b1;
          d.rsp_rdata = '0;
          d.psel      = 1'b0;
          d.penable   = 1'b0;
          d.cmd_ready = 1'b1;
        end else if (q.cnt != CNT_MAX) begin
          // Saturates rather than wraps; only reachable with TIMEOUT = 0.
          d.cnt = q.cnt + 1'b1;
        end
      end
      default: begin
        d.psel      = 1'b0;
        d.penable   = 1'b0;
        d.cmd_ready = 1'b0;
      end
    endcase
  end

  assign cmd_ready = q.cmd_ready;
  assign PSEL      = q.psel;
  assign PENABLE   = q.penable;
  assign PWRITE    = q.pwrite;
  assign PADDR     = q.paddr;
  assign PWDATA    = q.pwdata;
  assign rsp_valid = q.rsp_valid;
  assign rsp_rdata = q.rsp_rdata;
  assign rsp_err   = q.rsp_err;

endmodule
